disp_test_sched: RTL
====================

Name: disp_test_sched

Overview:
Controller for the 8-channel 32-bit display multiplexer.
- Generates the mux channel select `Test[2:0]`, either from switches (manual) or by timed auto-scan over unmasked channels.
- Arbitrates two writers (CPU, debug port) for the channel-0 latch and drives its `EN`, `Data0`, `LES0` and `point0` inputs.
- Sits between the CPU/debug bus and the display mux, ahead of the 7-seg driver.

Parameters:
DWELL, 1000, number of `tick` strobes spent on each channel in auto-scan (min 1).
DWELL_W, 10, width of the dwell counter; must satisfy 2^DWELL_W >= DWELL.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
tick  in  1  one-cycle dwell time-base strobe (e.g. 1 kHz)
auto_en  in  1  1 = auto-scan, 0 = manual
sw_sel  in  3  manual channel select
skip_mask  in  8  bit i = 1 excludes channel i from auto-scan
cpu_req  in  1  CPU write request, level
cpu_data  in  32  CPU display word
cpu_le  in  8  CPU blink enables
cpu_point  in  8  CPU decimal points
dbg_req  in  1  debug write request, level
dbg_data  in  32  debug display word
dbg_le  in  8  debug blink enables
dbg_point  in  8  debug decimal points
cpu_gnt  out  1  one-cycle grant, CPU write accepted
dbg_gnt  out  1  one-cycle grant, debug write accepted
Test  out  3  display mux channel select
EN  out  1  one-cycle latch enable for channel 0
Data0  out  32  channel-0 display word
LES0  out  8  channel-0 blink enables
point0  out  8  channel-0 decimal points
scan_wrap  out  1  one-cycle pulse when the scan wraps to its lowest channel

Behaviour:
- Reset (rst=0 at a clk edge):
  - Outputs: Test=0, EN=0, cpu_gnt=dbg_gnt=0, scan_wrap=0, Data0=32'hAA5555AA, LES0=8'hFF, point0=8'h00.
  - Internal: state=MANUAL, dwell counter=0, round-robin pointer favours CPU.
  - Reset mid-scan or mid-grant aborts immediately; no pending write survives.
- State MANUAL:
  - Test <= sw_sel every cycle (1-cycle latency).
  - auto_en=1 -> SCAN next cycle. Test keeps its value, counter=0.
- State SCAN:
  - Counter increments on each tick.
  - On tick with counter==DWELL-1: counter<=0, Test <= next channel above Test (mod 8) whose skip_mask bit is 0.
  - Wrapping 7->0 (or a search that passes channel 7) pulses scan_wrap for one cycle.
  - If the current channel becomes masked: advance on the next tick regardless of the counter; counter<=0.
  - skip_mask=8'hFF: Test forced to 0, counter held at 0, no scan_wrap.
  - auto_en=0 -> MANUAL next cycle; counter cleared.
- Arbiter:
  - Requests are sampled every cycle.
  - Single request -> that requester is granted.
  - Both requesting -> the requester not granted last wins (round-robin); the pointer updates only on a grant.
  - Grant is registered: in cycle N+1 after request cycle N, gnt=1 and EN=1.
  - Data0/LES0/point0 load the winner's cycle-N data and hold until the next grant.
  - A held request yields one write per cycle. Both held -> strict alternation CPU, DBG, CPU...
  - Never both gnt in one cycle. EN is exactly cpu_gnt|dbg_gnt.
- Arbiter and scan run independently. A write does not disturb Test (see optional feature).

Optional Feature:
DISP_WRITE_SNAP_EN
- Defined: in SCAN, any grant forces Test<=0 and counter<=0 in the same cycle EN is asserted, so a fresh CPU/debug value is shown immediately. The scan resumes from 0. No scan_wrap pulse. MANUAL is unaffected.
- Undefined: grants never affect Test or the counter.

Test Plan:
- Reset: rst=0 for 2 cycles, then 1 -> Test=0, EN=0, Data0=32'hAA5555AA, LES0=8'hFF, point0=0, both gnt=0.
- Manual: auto_en=0, sw_sel=3'd5 -> Test=5 one cycle later. sw_sel=3'd2 -> Test=2 next cycle.
- Scan with mask: DWELL=4, skip_mask=8'b0100_0110, auto_en=1 from Test=0 -> Test sequence 0,3,4,5,7,0 every 4 ticks. scan_wrap pulses once at 7->0. skip_mask=8'hFF -> Test=0 held.
- Single writer: cpu_req=1 for one cycle with cpu_data=32'h12345678, cpu_le=8'h0F -> next cycle cpu_gnt=EN=1, Data0=32'h12345678, LES0=8'h0F. Data0 holds after cpu_req drops.
- Contention: cpu_req=dbg_req=1 for 4 cycles, dbg_data=32'hDEADBEEF -> grants CPU, DBG, CPU, DBG on consecutive cycles. Data0 alternates accordingly. Never two grants in one cycle.
- Snap (DISP_WRITE_SNAP_EN defined): in SCAN at Test=5 mid-dwell, dbg_req pulse -> Test=0 in the EN cycle, counter restarts. Undefined -> Test stays 5.

Source files
------------

// File: rtl/disp_test_sched.sv
// disp_test_sched: channel-select scanner and channel-0 write arbiter for the 8-channel display mux
//   Optional feature macro: DISP_WRITE_SNAP_EN (a grant during auto-scan snaps Test and the dwell back to 0)
//   Ports:
//     clk, rst (sync, active-low), tick (dwell time base)
//     auto_en, sw_sel, skip_mask        : scan control
//     cpu_req/data/le/point             : CPU write channel
//     dbg_req/data/le/point             : debug write channel
//     cpu_gnt, dbg_gnt                  : one-cycle write grants
//     Test                              : mux channel select
//     EN, Data0, LES0, point0           : channel-0 latch interface (EN = cpu_gnt | dbg_gnt)
//     scan_wrap                         : one-cycle pulse when the scan wraps to its lowest channel
module disp_test_sched #(
   parameter int DWELL   = 1000,
   parameter int DWELL_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        auto_en,
   input  logic [2:0]  sw_sel,
   input  logic [7:0]  skip_mask,
   input  logic        cpu_req,
   input  logic [31:0] cpu_data,
   input  logic [7:0]  cpu_le,
   input  logic [7:0]  cpu_point,
   input  logic        dbg_req,
   input  logic [31:0] dbg_data,
   input  logic [7:0]  dbg_le,
   input  logic [7:0]  dbg_point,
   output logic        cpu_gnt,
   output logic        dbg_gnt,
   output logic [2:0]  Test,
   output logic        EN,
   output logic [31:0] Data0,
   output logic [7:0]  LES0,
   output logic [7:0]  point0,
   output logic        scan_wrap
);
   typedef enum logic {MANUAL, SCAN} state_t;
   state_t state, state_n;
   logic [DWELL_W-1:0] cnt, cnt_n;
   logic [2:0] test_n, nxt;
   logic wrap_n, nxt_wrap, found;
   logic prio_dbg, pick_cpu, pick_dbg, snap;
   // prio_dbg=1 means the CPU was granted last, so the debug port wins a tie
   assign pick_cpu = cpu_req & (~dbg_req | ~prio_dbg);
   assign pick_dbg = dbg_req & (~cpu_req | prio_dbg);
   assign EN = cpu_gnt | dbg_gnt;
`ifdef DISP_WRITE_SNAP_EN
   assign snap = pick_cpu | pick_dbg;
`else
   assign snap = 1'b0;
`endif
   // first unmasked channel above Test; i=8 returns to Test itself when it is the only one left
   always_comb begin
      nxt = Test;
      nxt_wrap = 1'b0;
      found = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (!found && !skip_mask[Test + 3'(i)]) begin
            nxt = Test + 3'(i);
            nxt_wrap = ({1'b0, Test} + 4'(i)) > 4'd7;
            found = 1'b1;
         end
      end
   end
   always_comb begin
      state_n = state;
      test_n = Test;
      cnt_n = cnt;
      wrap_n = 1'b0;
      if (state == MANUAL) begin
         cnt_n = '0;
         if (auto_en) state_n = SCAN;
         else test_n = sw_sel;
      end else if (!auto_en) begin
         state_n = MANUAL;
         cnt_n = '0;
      end else if (skip_mask == 8'hFF) begin
         test_n = 3'd0;
         cnt_n = '0;
      end else if (snap) begin
         test_n = 3'd0;
         cnt_n = '0;
      end else if (tick) begin
         // a masked current channel is left on the very next tick
         if (skip_mask[Test] || cnt == DWELL_W'(DWELL - 1)) begin
            test_n = nxt;
            cnt_n = '0;
            wrap_n = nxt_wrap;
         end else cnt_n = cnt + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= MANUAL;
         cnt <= '0;
         Test <= 3'd0;
         scan_wrap <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         Test <= test_n;
         scan_wrap <= wrap_n;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         cpu_gnt <= 1'b0;
         dbg_gnt <= 1'b0;
         prio_dbg <= 1'b0;
         Data0 <= 32'hAA5555AA;
         LES0 <= 8'hFF;
         point0 <= 8'h00;
      end else begin
         cpu_gnt <= pick_cpu;
         dbg_gnt <= pick_dbg;
         if (pick_cpu | pick_dbg) prio_dbg <= pick_cpu;
         if (pick_cpu) begin
            Data0 <= cpu_data;
            LES0 <= cpu_le;
            point0 <= cpu_point;
         end else if (pick_dbg) begin
            Data0 <= dbg_data;
            LES0 <= dbg_le;
            point0 <= dbg_point;
         end
      end
   end
endmodule
